// File: rtl/processor_channel_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lvda_pkg
// Brief    : Shared types and constants for the processor-channel serializer.
// Revision : 1.0
// ============================================================================
package lvda_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        GAP   = 2'd3
    } ser_state_t;

    localparam int   LVDC_WORD_WIDTH = 26;
    localparam logic CHAN_C2         = 1'b0;
    localparam logic CHAN_C3         = 1'b1;

endpackage
`default_nettype wire

// File: rtl/processor_channel_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : processor_channel_serializer_if
// Brief    : Channel strobes/data in, serial word stream and status out.
// Revision : 1.0
// ============================================================================
interface processor_channel_serializer_if
    import lvda_pkg::*;
#(
    parameter int WORD_WIDTH = LVDC_WORD_WIDTH
);
    logic                  V1;
    logic                  C2R;
    logic                  C3R;
    logic [WORD_WIDTH-1:0] D2;
    logic [WORD_WIDTH-1:0] D3;
    logic                  SDO;
    logic                  SVALID;
    logic                  BUSY;
    logic                  DONE;
    logic                  CHAN;
    logic [1:0]            OVR;

    modport master (
        output V1, C2R, C3R, D2, D3,
        input  SDO, SVALID, BUSY, DONE, CHAN, OVR
    );

    modport slave (
        input  V1, C2R, C3R, D2, D3,
        output SDO, SVALID, BUSY, DONE, CHAN, OVR
    );
endinterface
`default_nettype wire

// File: rtl/processor_channel_serializer_channel_req_latch.sv
`default_nettype none
// ============================================================================
// Module   : channel_req_latch
// Brief    : Strobe edge detect, holding register, pending and overrun flags.
// Revision : 1.0
// ============================================================================
module channel_req_latch
    import lvda_pkg::*;
#(
    parameter int WIDTH = LVDC_WORD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             strobe,
    input  logic [WIDTH-1:0] data,
    input  logic             take,
    output logic             pend,
    output logic [WIDTH-1:0] hold,
    output logic             ovr
);
    logic             r_strobe_q;
    logic             r_pend;
    logic             r_ovr;
    logic [WIDTH-1:0] r_hold;
    logic             w_req;

    assign w_req = strobe & ~r_strobe_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_strobe_q <= 1'b0;
            r_pend     <= 1'b0;
            r_ovr      <= 1'b0;
            r_hold     <= '0;
        end else begin
            r_strobe_q <= strobe;
            if (w_req) begin
                r_hold <= data;
            end
            // A word taken on this same edge has already reached the shifter, so nothing is lost.
            if (w_req && r_pend && !take) begin
                r_ovr <= 1'b1;
            end
            r_pend <= w_req | (r_pend & ~take);
        end
    end

    assign pend = r_pend;
    assign hold = r_hold;
    assign ovr  = r_ovr;

endmodule
`default_nettype wire

// File: rtl/processor_channel_serializer.sv
`default_nettype none
// ============================================================================
// Module   : processor_channel_serializer
// Brief    : Serializes C2/C3 channel words LSB first with odd parity and gap.
// Revision : 1.0
// ============================================================================
module processor_channel_serializer
    import lvda_pkg::*;
#(
    parameter int WORD_WIDTH = LVDC_WORD_WIDTH,
    parameter int PARITY_EN  = 1,
    parameter int GAP_BITS   = 2
) (
    input  logic                          SIM_CLK,
    input  logic                          SIM_RST,
    processor_channel_serializer_if.slave bus
);
    localparam int BIT_CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int GAP_CNT_W = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP_BITS);

    logic                  w_pend2, w_pend3;
    logic                  w_ovr2, w_ovr3;
    logic [WORD_WIDTH-1:0] w_hold2, w_hold3;
    logic                  w_take2, w_take3;
    logic [WORD_WIDTH-1:0] w_load_word;

    ser_state_t            r_state, w_state_next;
    logic [WORD_WIDTH-1:0] r_sr, w_sr_next;
    logic [BIT_CNT_W-1:0]  r_bitcnt, w_bitcnt_next;
    logic [GAP_CNT_W-1:0]  r_gapcnt, w_gapcnt_next;
    logic                  r_par, w_par_next;
    logic                  r_sdo, w_sdo_next;
    logic                  r_svalid, w_svalid_next;
    logic                  r_done, w_done_next;
    logic                  r_chan, w_chan_next;

    channel_req_latch #(.WIDTH(WORD_WIDTH)) u_c2_latch (
        .clk    (SIM_CLK),
        .rst_n  (SIM_RST),
        .strobe (bus.C2R),
        .data   (bus.D2),
        .take   (w_take2),
        .pend   (w_pend2),
        .hold   (w_hold2),
        .ovr    (w_ovr2)
    );

    channel_req_latch #(.WIDTH(WORD_WIDTH)) u_c3_latch (
        .clk    (SIM_CLK),
        .rst_n  (SIM_RST),
        .strobe (bus.C3R),
        .data   (bus.D3),
        .take   (w_take3),
        .pend   (w_pend3),
        .hold   (w_hold3),
        .ovr    (w_ovr3)
    );

    assign w_load_word = w_pend2 ? w_hold2 : w_hold3;

    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            r_state  <= IDLE;
            r_sr     <= '0;
            r_bitcnt <= '0;
            r_gapcnt <= '0;
            r_par    <= 1'b0;
            r_sdo    <= 1'b0;
            r_svalid <= 1'b0;
            r_done   <= 1'b0;
            r_chan   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_sr     <= w_sr_next;
            r_bitcnt <= w_bitcnt_next;
            r_gapcnt <= w_gapcnt_next;
            r_par    <= w_par_next;
            r_sdo    <= w_sdo_next;
            r_svalid <= w_svalid_next;
            r_done   <= w_done_next;
            r_chan   <= w_chan_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_sr_next     = r_sr;
        w_bitcnt_next = r_bitcnt;
        w_gapcnt_next = r_gapcnt;
        w_par_next    = r_par;
        w_sdo_next    = r_sdo;
        w_svalid_next = r_svalid;
        w_done_next   = 1'b0;
        w_chan_next   = r_chan;
        w_take2       = 1'b0;
        w_take3       = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_pend2 || w_pend3) begin
                    w_take2       = w_pend2;
                    w_take3       = ~w_pend2;
                    w_chan_next   = w_pend2 ? CHAN_C2 : CHAN_C3;
                    w_sr_next     = w_load_word;
                    w_sdo_next    = w_load_word[0];
                    w_par_next    = w_load_word[0];
                    w_bitcnt_next = '0;
                    w_svalid_next = 1'b1;
                    w_state_next  = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.V1) begin
                    if (r_bitcnt == LAST_BIT) begin
                        if (PARITY_EN != 0) begin
                            w_sdo_next   = ~r_par;
                            w_state_next = PAR;
                        end else begin
                            w_svalid_next = 1'b0;
                            w_sdo_next    = 1'b0;
                            w_gapcnt_next = '0;
                            w_done_next   = 1'b1;
                            w_state_next  = GAP;
                        end
                    end else begin
                        w_sr_next     = r_sr >> 1;
                        w_sdo_next    = r_sr[1];
                        w_par_next    = r_par ^ r_sr[1];
                        w_bitcnt_next = r_bitcnt + BIT_CNT_W'(1);
                    end
                end
            end
            PAR: begin
                if (bus.V1) begin
                    w_svalid_next = 1'b0;
                    w_sdo_next    = 1'b0;
                    w_gapcnt_next = '0;
                    w_done_next   = 1'b1;
                    w_state_next  = GAP;
                end
            end
            GAP: begin
                // Exit is checked before counting so GAP_BITS = 0 leaves after one cycle.
                if (r_gapcnt == GAP_LAST) begin
                    w_state_next = IDLE;
                end else if (bus.V1) begin
                    w_gapcnt_next = r_gapcnt + GAP_CNT_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.SDO    = r_sdo;
    assign bus.SVALID = r_svalid;
    assign bus.BUSY   = (r_state != IDLE);
    assign bus.DONE   = r_done;
    assign bus.CHAN   = r_chan;
    assign bus.OVR    = {w_ovr3, w_ovr2};

endmodule
`default_nettype wire

// File: tb/tb_processor_channel_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_processor_channel_serializer
// Brief    : Directed self-checking bench: default DUT plus a no-parity/no-gap DUT.
// Revision : 1.0
// ============================================================================
module tb_processor_channel_serializer;
    import lvda_pkg::*;

    logic clk;
    logic rst;

    processor_channel_serializer_if #(.WORD_WIDTH(26)) if_a ();
    processor_channel_serializer_if #(.WORD_WIDTH(26)) if_b ();

    processor_channel_serializer #(
        .WORD_WIDTH (26),
        .PARITY_EN  (1),
        .GAP_BITS   (2)
    ) dut_a (
        .SIM_CLK (clk),
        .SIM_RST (rst),
        .bus     (if_a)
    );

    processor_channel_serializer #(
        .WORD_WIDTH (26),
        .PARITY_EN  (0),
        .GAP_BITS   (0)
    ) dut_b (
        .SIM_CLK (clk),
        .SIM_RST (rst),
        .bus     (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   v1_mode_a = 0;
    int   v1_mode_b = 0;
    logic bits_a[$];
    logic chan_a[$];
    logic bits_b[$];
    int   rise_b[$];
    int   fall_b[$];
    int   done_b[$];
    int   done_cnt_a = 0;
    int   done_cnt_b = 0;
    int   gap_v1_a = 0;
    logic prev_sv_b = 1'b0;
    logic [31:0] w;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample registered outputs, then set V1 for the coming edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (if_a.DONE) done_cnt_a++;
        if (if_b.DONE) begin
            done_cnt_b++;
            done_b.push_back(cyc);
        end
        if (if_b.SVALID && !prev_sv_b) rise_b.push_back(cyc);
        if (!if_b.SVALID && prev_sv_b) fall_b.push_back(cyc);
        prev_sv_b = if_b.SVALID;
        if_a.V1 = (v1_mode_a == 4) ? (cyc % 4 == 0) : (v1_mode_a == 1);
        if_b.V1 = (v1_mode_b == 1);
        if (if_a.V1 && if_a.SVALID) begin
            bits_a.push_back(if_a.SDO);
            chan_a.push_back(if_a.CHAN);
        end
        if (if_a.V1 && if_a.BUSY && !if_a.SVALID) gap_v1_a++;
        if (if_b.V1 && if_b.SVALID) bits_b.push_back(if_b.SDO);
    endtask

    task automatic clear_a();
        bits_a.delete();
        chan_a.delete();
        done_cnt_a = 0;
        gap_v1_a   = 0;
    endtask

    task automatic wait_done_a(input int target, input int budget);
        int k;
        k = 0;
        while (!(done_cnt_a >= target && !if_a.BUSY) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) check_value("timeout_a", 32'(done_cnt_a), 32'(target));
    endtask

    function automatic logic [31:0] word_a(input int base);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 26; i++) begin
            if (base + i < bits_a.size()) r[i] = bits_a[base + i];
        end
        return r;
    endfunction

    function automatic logic [31:0] word_b(input int base);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 26; i++) begin
            if (base + i < bits_b.size()) r[i] = bits_b[base + i];
        end
        return r;
    endfunction

    function automatic logic bit_a(input int idx);
        return (idx < bits_a.size()) ? bits_a[idx] : 1'bx;
    endfunction

    function automatic logic ch_a(input int idx);
        return (idx < chan_a.size()) ? chan_a[idx] : 1'bx;
    endfunction

    initial begin
        rst = 1'b0;
        if_a.V1 = 1'b0; if_a.C2R = 1'b0; if_a.C3R = 1'b0; if_a.D2 = '0; if_a.D3 = '0;
        if_b.V1 = 1'b0; if_b.C2R = 1'b0; if_b.C3R = 1'b0; if_b.D2 = '0; if_b.D3 = '0;
        repeat (3) tick();

        check_value("rst_svalid", 32'(if_a.SVALID), 32'd0);
        check_value("rst_busy",   32'(if_a.BUSY),   32'd0);
        check_value("rst_sdo",    32'(if_a.SDO),    32'd0);
        check_value("rst_done",   32'(if_a.DONE),   32'd0);
        check_value("rst_chan",   32'(if_a.CHAN),   32'd0);
        check_value("rst_ovr",    32'(if_a.OVR),    32'd0);
        rst = 1'b1;
        repeat (2) tick();

        // Latency and basic word 0x2AAAAAA from channel 2
        if_a.D2  = 26'h2AAAAAA;
        if_a.C2R = 1'b1;
        tick();
        check_value("lat_n1_svalid", 32'(if_a.SVALID), 32'd0);
        if_a.C2R = 1'b0;
        tick();
        check_value("lat_n2_svalid", 32'(if_a.SVALID), 32'd1);
        check_value("lat_n2_sdo",    32'(if_a.SDO),    32'd0);
        check_value("lat_n2_busy",   32'(if_a.BUSY),   32'd1);
        check_value("lat_n2_chan",   32'(if_a.CHAN),   32'd0);
        v1_mode_a = 4;
        wait_done_a(1, 600);
        check_value("basic_nbits", 32'(bits_a.size()), 32'd27);
        check_value("basic_word",  word_a(0),          32'h2AAAAAA);
        check_value("basic_par",   32'(bit_a(26)),     32'd0);
        check_value("basic_done",  32'(done_cnt_a),    32'd1);
        check_value("basic_gapv1", 32'(gap_v1_a),      32'd2);
        check_value("basic_chan",  32'(ch_a(0)),       32'd0);

        // Simultaneous requests: C2 first, then C3
        repeat (3) tick();
        clear_a();
        if_a.D2 = 26'h0000001;
        if_a.D3 = 26'h0000003;
        if_a.C2R = 1'b1;
        if_a.C3R = 1'b1;
        tick();
        if_a.C2R = 1'b0;
        if_a.C3R = 1'b0;
        wait_done_a(2, 800);
        check_value("prio_nbits", 32'(bits_a.size()), 32'd54);
        check_value("prio_word1", word_a(0),          32'h0000001);
        check_value("prio_par1",  32'(bit_a(26)),     32'd0);
        check_value("prio_chan1", 32'(ch_a(0)),       32'd0);
        check_value("prio_word2", word_a(27),         32'h0000003);
        check_value("prio_par2",  32'(bit_a(53)),     32'd1);
        check_value("prio_chan2", 32'(ch_a(27)),      32'd1);
        check_value("prio_ovr",   32'(if_a.OVR),      32'd0);

        // Overrun on C3 during a C2 transfer
        repeat (3) tick();
        clear_a();
        if_a.D2  = 26'h0000007;
        if_a.C2R = 1'b1;
        tick();
        if_a.C2R = 1'b0;
        repeat (3) tick();
        if_a.D3  = 26'h0000005;
        if_a.C3R = 1'b1;
        tick();
        if_a.C3R = 1'b0;
        repeat (5) tick();
        if_a.D3  = 26'h000000F;
        if_a.C3R = 1'b1;
        tick();
        if_a.C3R = 1'b0;
        wait_done_a(2, 800);
        check_value("ovr_flags", 32'(if_a.OVR),  32'h2);
        check_value("ovr_word1", word_a(0),      32'h0000007);
        check_value("ovr_par1",  32'(bit_a(26)), 32'd0);
        check_value("ovr_word2", word_a(27),     32'h000000F);
        check_value("ovr_par2",  32'(bit_a(53)), 32'd1);
        check_value("ovr_chan2", 32'(ch_a(27)),  32'd1);

        // Reset in the middle of a word
        repeat (3) tick();
        clear_a();
        if_a.D2  = 26'h3FFFFFF;
        if_a.C2R = 1'b1;
        tick();
        if_a.C2R = 1'b0;
        begin
            int k;
            k = 0;
            while (bits_a.size() < 11 && k < 400) begin
                tick();
                k++;
            end
            if (k >= 400) check_value("timeout_mid", 32'(bits_a.size()), 32'd11);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_value("midrst_svalid", 32'(if_a.SVALID), 32'd0);
        check_value("midrst_busy",   32'(if_a.BUSY),   32'd0);
        check_value("midrst_done",   32'(if_a.DONE),   32'd0);
        check_value("midrst_ovr",    32'(if_a.OVR),    32'd0);
        repeat (2) tick();
        clear_a();
        if_a.D2  = 26'h1234567;
        if_a.C2R = 1'b1;
        tick();
        if_a.C2R = 1'b0;
        wait_done_a(1, 600);
        check_value("after_rst_nbits", 32'(bits_a.size()), 32'd27);
        check_value("after_rst_word",  word_a(0),          32'h1234567);
        check_value("after_rst_par",   32'(bit_a(26)),     32'd1);

        // No parity, no gap, V1 held high, two back-to-back words
        v1_mode_b = 1;
        if_b.D2  = 26'h2AAAAAA;
        if_b.D3  = 26'h1555555;
        if_b.C2R = 1'b1;
        if_b.C3R = 1'b1;
        tick();
        if_b.C2R = 1'b0;
        if_b.C3R = 1'b0;
        begin
            int k;
            k = 0;
            while (!(done_cnt_b >= 2 && !if_b.BUSY) && k < 300) begin
                tick();
                k++;
            end
            if (k >= 300) check_value("timeout_b", 32'(done_cnt_b), 32'd2);
        end
        check_value("sweep_nbits", 32'(bits_b.size()), 32'd52);
        check_value("sweep_word1", word_b(0),          32'h2AAAAAA);
        check_value("sweep_word2", word_b(26),         32'h1555555);
        if (rise_b.size() >= 2 && fall_b.size() >= 1 && done_b.size() >= 1) begin
            check_value("sweep_len1",    32'(fall_b[0] - rise_b[0]), 32'd26);
            check_value("sweep_done_at", 32'(done_b[0] - fall_b[0]), 32'd0);
            check_value("sweep_b2b",     32'(rise_b[1] - done_b[0]), 32'd2);
        end else begin
            check_value("sweep_edges", 32'(rise_b.size()), 32'd2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/processor_channel_serializer.md
Name: processor_channel_serializer

Overview:
- Downstream consumer of the processor-store channel read strobes C2R and C3R.
- A rising edge on either strobe captures that channel's parallel data word into a holding register.
- The word is then shifted out bit-serially toward the LVDC, one bit per V1 bit-time strobe, with an optional odd-parity bit and an inter-word gap.
- Arbitrates between the two channels and flags overruns.

Parameters:
- WORD_WIDTH, 26: data bits per word (sign + 25 magnitude).
- PARITY_EN, 1: when 1, append an odd-parity bit after the data bits.
- GAP_BITS, 2: V1 bit-times of idle (SVALID=0) inserted after every word.

Ports:
- SIM_CLK  input  1  system clock; all state changes on its rising edge.
- SIM_RST  input  1  synchronous active-low reset; when 0 at a clock edge, all state returns to reset values.
- V1  input  1  bit-time strobe, one SIM_CLK cycle wide.
- C2R  input  1  channel-2 read strobe (level); rising edge = request.
- C3R  input  1  channel-3 read strobe (level); rising edge = request.
- D2  input  WORD_WIDTH  channel-2 parallel data.
- D3  input  WORD_WIDTH  channel-3 parallel data.
- SDO  output  1  serial data out, LSB first.
- SVALID  output  1  SDO holds a valid data or parity bit.
- BUSY  output  1  FSM is not in IDLE.
- DONE  output  1  one-cycle pulse when the last bit of a word ends.
- CHAN  output  1  channel being sent: 0 = C2, 1 = C3.
- OVR  output  2  sticky overrun flags: [0] = C2, [1] = C3.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; edge-detect history regs = 0; pending flags = 0; holding registers = 0.
- Edge detect:
  - req2 = C2R & ~C2R_q. On a req2 cycle, D2 is captured into H2 and pend2 is set in the same cycle.
  - Same rule for C3 (req3, H3, pend3).
  - If pend2 is already set when req2 occurs: OVR[0] sets, H2 is overwritten, pend2 stays set. Same for C3 / OVR[1].
  - OVR bits clear only on reset.
- FSM states: IDLE, SHIFT, PAR, GAP.
- IDLE:
  - If pend2 or pend3 is set, go to SHIFT on the next cycle. C2 has priority when both are pending.
  - On that transition: load the selected H into shift register SR; clear that pend flag; set CHAN; set SVALID=1; SDO = SR[0]; load bitcnt = 0.
  - A request and IDLE exit can occur in the same cycle only when the pend flag was already set beforehand. Minimum latency from a request edge to SVALID=1 is 2 cycles.
- SHIFT:
  - Each V1 pulse: if bitcnt == WORD_WIDTH-1, go to PAR (PARITY_EN=1) or to GAP (PARITY_EN=0). Otherwise shift SR right, SDO = next bit, bitcnt += 1.
  - Parity is accumulated as bits are presented: par ^= SDO.
- PAR: SDO = ~(XOR of all data bits), giving odd parity over data plus parity bit. The next V1 moves to GAP.
- DONE: asserted for one cycle on the cycle the FSM enters GAP.
- GAP:
  - On entry: SVALID=0, SDO=0, gapcnt = 0.
  - Each V1 increments gapcnt. When gapcnt reaches GAP_BITS, go to IDLE.
  - GAP_BITS = 0: exit to IDLE on the cycle after entry.
- BUSY = 1 in SHIFT, PAR and GAP.
- Requests arriving while BUSY are latched (pend/H) and served after GAP. CHAN holds its value until the next word starts.
- Simultaneous req2 and req3 in IDLE: both are captured; C2 is sent first, then C3 after the gap. No overrun is flagged.
- V1 held high continuously (test mode): one bit per clock cycle, all rules unchanged.
- Reset mid-word: SIM_RST=0 at any edge aborts the word. SVALID, BUSY and DONE are 0 on the following cycle; pending and OVR flags are cleared.
- Counter widths: bitcnt = $clog2(WORD_WIDTH) bits; gapcnt = $clog2(GAP_BITS+1) bits. Neither wraps in legal operation.

Decomposition:
- Shared package lvda_pkg:
  - ser_state_t enum (IDLE, SHIFT, PAR, GAP);
  - LVDC_WORD_WIDTH = 26;
  - CHAN_C2 = 0, CHAN_C3 = 1.
- Sub-module channel_req_latch, instantiated twice. Contents: edge detect, holding register, pend flag, overrun flag. Interface: strobe, data, take (clear) → pend, hold, ovr.
- The FSM, shift register and parity logic live in the top module.

Test Plan:
- Basic word: D2 = 26'h2AAAAAA, C2R pulse, V1 every 4 cycles → SDO sequence 0,1,0,1,… (LSB first) over 26 V1 pulses; parity bit = 0 (13 ones already odd); DONE pulse; CHAN = 0; BUSY drops after 2 gap bit-times.
- Priority: C2R and C3R rise in the same cycle with D2 = 26'h0000001, D3 = 26'h0000003 → C2 word sent first with parity 0; then C3 word with parity 1 after the gap; CHAN 0→1; OVR = 2'b00.
- Overrun: C3R pulses twice during a C2 transfer, D3 = 26'h0000005 then 26'h000000F → OVR[1] = 1; C3 word sent = 26'h000000F.
- Latency: from IDLE, C2R rises at cycle n → SVALID = 1 at cycle n+2, SDO = D2[0].
- Reset mid-word: SIM_RST = 0 for one cycle after bit 10 → next cycle SVALID = 0, BUSY = 0, OVR = 0; a new C2R request then sends a full 26-bit word.
- Parameter sweep: PARITY_EN = 0, GAP_BITS = 0, V1 held at 1 → word completes in exactly 26 cycles of SVALID; DONE follows the last bit; back-to-back pending word starts 2 cycles after DONE.
